// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read/1-write register file with zero register, write bypass and pending-write scoreboard
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE3,
  input  logic              ISS,
  input  logic [ADDR_W-1:0] ISS_RD,
  output logic              BUSY1,
  output logic              BUSY2
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic              w_wr_ok, w_iss_ok, w_z1, w_z2, w_b1, w_b2;
  // writability and per-port zero/bypass hits
  always_comb begin
    w_wr_ok  = WE3 && !(ZERO_REG != 0 && A3 == '0);
    w_iss_ok = ISS && !(ZERO_REG != 0 && ISS_RD == '0);
    w_z1     = ZERO_REG != 0 && A1 == '0;
    w_z2     = ZERO_REG != 0 && A2 == '0;
    w_b1     = BYPASS != 0 && WE3 && A3 == A1;
    w_b2     = BYPASS != 0 && WE3 && A3 == A2;
  end
  // register storage and scoreboard; a new issue supersedes a completing write to the same register
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_ok) r_regs[A3] <= WD;
      if (WE3) r_pend[A3] <= 1'b0;
      if (w_iss_ok) r_pend[ISS_RD] <= 1'b1;
    end
  end
  // combinational read data and busy flags; bypassed data is valid so it is never busy
  always_comb begin
    RD1   = w_z1 ? '0 : w_b1 ? WD : r_regs[A1];
    RD2   = w_z2 ? '0 : w_b2 ? WD : r_regs[A2];
    BUSY1 = !w_z1 && !w_b1 && r_pend[A1];
    BUSY2 = !w_z2 && !w_b2 && r_pend[A2];
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench running all four ZERO_REG/BYPASS configurations in parallel
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        res = 1'b1, we = 1'b0, iss = 1'b0;
  logic [4:0]  a1 = '0, a2 = '0, a3 = '0, issrd = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1 [4];
  logic [31:0] rd2 [4];
  logic        bz1 [4];
  logic        bz2 [4];
  typedef struct packed {
    logic [3:0][31:0] rd1;
    logic [3:0][31:0] rd2;
    logic [3:0]       b1;
    logic [3:0]       b2;
  } exp_t;
  exp_t        q[$];
  exp_t        e;
  logic [31:0] m_regs [4][32];
  bit          m_pend [4][32];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  // configuration c: ZERO_REG = c/2, BYPASS = c%2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(g / 2), .BYPASS(g % 2)) dut (
      .clk(clk), .res(res), .A1(a1), .A2(a2), .RD1(rd1[g]), .RD2(rd2[g]),
      .A3(a3), .WD(wd), .WE3(we), .ISS(iss), .ISS_RD(issrd),
      .BUSY1(bz1[g]), .BUSY2(bz2[g])
    );
  end
  function automatic logic [31:0] exp_rd(int c, logic [4:0] a);
    if (c >= 2 && a == 0) return 32'h0;
    if (c % 2 == 1 && we && a3 == a) return wd;
    return m_regs[c][a];
  endfunction
  function automatic logic exp_busy(int c, logic [4:0] a);
    if (c >= 2 && a == 0) return 1'b0;
    if (c % 2 == 1 && we && a3 == a) return 1'b0;
    return m_pend[c][a];
  endfunction
  // reference effect of the clock edge that just happened, using the inputs held across it
  task automatic model_edge();
    for (int c = 0; c < 4; c++) begin
      if (res) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[c][r] = 32'h0;
          m_pend[c][r] = 1'b0;
        end
      end else begin
        if (we && !(c >= 2 && a3 == 0)) m_regs[c][a3] = wd;
        if (we) m_pend[c][a3] = 1'b0;
        if (iss && !(c >= 2 && issrd == 0)) m_pend[c][issrd] = 1'b1;
      end
    end
  endtask
  task automatic drive(input logic r, input logic w, input logic i, input logic [4:0] x1,
                       input logic [4:0] x2, input logic [4:0] x3, input logic [4:0] xi,
                       input logic [31:0] d);
    exp_t x;
    @(posedge clk);
    model_edge();
    #1;
    res = r; we = w; iss = i; a1 = x1; a2 = x2; a3 = x3; issrd = xi; wd = d;
    for (int c = 0; c < 4; c++) begin
      x.rd1[c] = exp_rd(c, a1);
      x.rd2[c] = exp_rd(c, a2);
      x.b1[c]  = exp_busy(c, a1);
      x.b2[c]  = exp_busy(c, a2);
    end
    q.push_back(x);
  endtask
  task automatic chk(input string n, input int c, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t a1=%0d a2=%0d got %h expected %h", n, c, $time, a1, a2, got, want);
    end
  endtask
  // monitor: compare whatever the driver last expected against the settled outputs
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int c = 0; c < 4; c++) begin
        chk("rd1", c, rd1[c], e.rd1[c]);
        chk("rd2", c, rd2[c], e.rd2[c]);
        chk("busy1", c, {31'h0, bz1[c]}, {31'h0, e.b1[c]});
        chk("busy2", c, {31'h0, bz2[c]}, {31'h0, e.b2[c]});
      end
    end
  end
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) drive(0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0);
    drive(0, 1, 0, 0, 0, 5, 0, 42);
    drive(0, 1, 0, 10, 5, 10, 0, 100);
    drive(0, 0, 0, 10, 5, 0, 0, 0);
    drive(0, 0, 0, 10, 5, 5, 0, 7);
    drive(0, 0, 0, 5, 5, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 32'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 7, 7, 7, 0, 32'h1234);
    drive(0, 0, 0, 7, 7, 0, 0, 0);
    drive(0, 0, 1, 9, 9, 0, 9, 0);
    drive(0, 0, 0, 9, 9, 0, 0, 0);
    drive(0, 1, 0, 9, 9, 9, 0, 32'h99);
    drive(0, 0, 0, 9, 9, 0, 0, 0);
    drive(0, 0, 1, 9, 9, 0, 9, 0);
    drive(0, 1, 1, 9, 9, 9, 9, 32'h77);
    drive(0, 0, 0, 9, 9, 0, 0, 0);
    drive(0, 1, 1, 3, 3, 3, 3, 55);
    drive(0, 0, 0, 3, 3, 0, 0, 0);
    drive(1, 1, 1, 3, 3, 3, 3, 99);
    drive(0, 0, 0, 3, 3, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      logic [4:0] r1, r2, r3, ri;
      logic       narrow;
      narrow = $urandom_range(0, 1) == 1;
      r1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r3 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ri = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            r1, r2, r3, ri, $urandom);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue left %0d entries, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
